// File: rtl/fns_cac_pkg.sv
// Shared constants, state enum and Fibonacci weight lookup for the FNS encoder.
package fns_cac_pkg;

    localparam int FNS_DATA_W = 7;
    localparam int FNS_CODE_W = 8;
    localparam int FNS_CNT_W  = $clog2(FNS_CODE_W);

    // Largest value reachable with all eight weights set: 1+2+3+5+8+13+21+34.
    localparam logic [FNS_DATA_W-1:0] FNS_MAX = 7'd87;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [FNS_DATA_W-1:0] fns_weight(input logic [FNS_CNT_W-1:0] idx);
        logic [FNS_DATA_W-1:0] w;
        case (idx)
            3'd0:    w = 7'd1;
            3'd1:    w = 7'd2;
            3'd2:    w = 7'd3;
            3'd3:    w = 7'd5;
            3'd4:    w = 7'd8;
            3'd5:    w = 7'd13;
            3'd6:    w = 7'd21;
            default: w = 7'd34;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fns_cac_encoder_if.sv
// Input/output handshake bundle of the FNS encoder; slave = encoder side.
interface fns_cac_encoder_if;
    import fns_cac_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [FNS_DATA_W-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [FNS_CODE_W-1:0] code_out;
    logic                  err_flag;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, code_out, err_flag
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, code_out, err_flag
    );

endinterface

// File: rtl/fns_greedy_step.sv
// One greedy Fibonacci digit: take the weight if the remainder can afford it.
// Latency: combinational.
// Backpressure: none.
module fns_greedy_step
    import fns_cac_pkg::*;
#(
    parameter int DATA_W = FNS_DATA_W
) (
    input  logic [DATA_W-1:0] remainder,
    input  logic [DATA_W-1:0] weight,
    output logic              bit_set,
    output logic [DATA_W-1:0] new_remainder
);

    // Subtraction only happens on the taken branch, so it cannot wrap.
    always_comb begin
        bit_set       = (remainder >= weight);
        new_remainder = bit_set ? (remainder - weight) : remainder;
    end

endmodule

// File: rtl/fns_cac_encoder.sv
// Binary to Fibonacci (FNS) codeword encoder, one digit per cycle MSB first.
// Latency: result valid 9 edges after accept (counting the accept edge), 1 for out-of-range input.
// Backpressure: accepts only in IDLE; holds result in DONE until out_ready.
module fns_cac_encoder
    import fns_cac_pkg::*;
#(
    parameter int DATA_W = FNS_DATA_W,
    parameter int CODE_W = FNS_CODE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    fns_cac_encoder_if.slave   bus
);

    localparam int                CNT_W    = $clog2(CODE_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CODE_W - 1);

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   rem_q;
    logic [CODE_W-1:0]   code_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic                step_bit;
    logic [DATA_W-1:0]   step_rem;
    logic                in_fire;
    logic                in_range;

    assign in_fire  = bus.in_valid && (state_q == IDLE);
    assign in_range = (bus.in_data <= FNS_MAX);

    fns_greedy_step #(.DATA_W(DATA_W)) u_step (
        .remainder     (rem_q),
        .weight        (fns_weight(cnt_q)),
        .bit_set       (step_bit),
        .new_remainder (step_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_fire) state_d = in_range ? ENC : DONE;
            ENC:  if (cnt_q == '0) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            code_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        code_q <= '0;
                        err_q  <= !in_range;
                        if (in_range) begin
                            rem_q <= bus.in_data;
                            cnt_q <= CNT_LAST;
                        end
                    end
                end
                ENC: begin
                    code_q[cnt_q] <= step_bit;
                    rem_q         <= step_rem;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.code_out  = code_q;
    assign bus.err_flag  = err_q;

endmodule

// File: tb/tb_fns_cac_encoder.sv
// Directed and randomized checks of fns_cac_encoder against a greedy Fibonacci reference.
module tb_fns_cac_encoder;
    import fns_cac_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   xfers    = 0;
    int   weights [8] = '{1, 2, 3, 5, 8, 13, 21, 34};

    fns_cac_encoder_if bus ();

    fns_cac_encoder #(.DATA_W(7), .CODE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) xfers++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_code(input int v);
        int r;
        logic [7:0] c;
        r = v;
        c = '0;
        for (int i = 7; i >= 0; i--) begin
            if (r >= weights[i]) begin
                c[i] = 1'b1;
                r    = r - weights[i];
            end
        end
        return c;
    endfunction

    function automatic int fns_value(input logic [7:0] c);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) if (c[i]) s += weights[i];
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the release edge.
    task automatic send(input logic [6:0] d, input int hold, input bit noisy,
                        output logic [7:0] code, output logic err, output int lat);
        int n;
        int x0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", bus.in_ready, 1);
        x0 = xfers;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 7'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            if (noisy) begin
                bus.out_ready = 1'($urandom);
                bus.in_valid  = 1'($urandom);
                bus.in_data   = 7'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("out_valid_rise", bus.out_valid, 1);
        code = bus.code_out;
        err  = bus.err_flag;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_code", bus.code_out, code);
            check("hold_err", bus.err_flag, err);
            check("hold_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        check("no_xfer_before_release", xfers - x0, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_valid", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);
        check("single_xfer", xfers - x0, 1);
    endtask

    initial begin
        logic [7:0] code;
        logic       err;
        int         lat;
        int         x0;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_code", bus.code_out, 0);
        check("rst_err", bus.err_flag, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send(7'd87, 0, 1'b0, code, err, lat);
        check("d87_code", code, 8'hFF);
        check("d87_err", err, 0);
        check("d87_lat", lat, 9);

        send(7'd54, 0, 1'b0, code, err, lat);
        check("d54_code", code, 8'hAA);
        check("d54_err", err, 0);

        send(7'd0, 0, 1'b0, code, err, lat);
        check("d0_code", code, 8'h00);
        check("d0_err", err, 0);

        send(7'd100, 0, 1'b0, code, err, lat);
        check("d100_err", err, 1);
        check("d100_code", code, 8'h00);
        check("d100_lat", lat, 1);

        send(7'd1, 0, 1'b0, code, err, lat);
        check("err_cleared", err, 0);
        check("d1_code", code, 8'h01);

        send(7'd54, 5, 1'b0, code, err, lat);
        check("hold5_code", code, 8'hAA);

        // Abandon a word four steps into encoding.
        x0 = xfers;
        bus.in_valid = 1'b1;
        bus.in_data  = 7'd87;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_code", bus.code_out, 0);
        check("midrst_err", bus.err_flag, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("midrst_idle_valid", bus.out_valid, 0);
        end
        check("midrst_no_output", xfers - x0, 0);

        send(7'd20, 0, 1'b0, code, err, lat);
        check("d20_code", code, 8'h2A);
        check("d20_sum", fns_value(code), 20);
        check("d20_lat", lat, 9);

        for (int v = 0; v < 128; v++) begin
            send(7'(v), $urandom_range(0, 3), 1'b1, code, err, lat);
            if (v <= 87) begin
                check($sformatf("sweep_code_%0d", v), code, ref_code(v));
                check($sformatf("sweep_sum_%0d", v), fns_value(code), v);
                check($sformatf("sweep_err_%0d", v), err, 0);
                check($sformatf("sweep_lat_%0d", v), lat, 9);
            end else begin
                check($sformatf("sweep_err_%0d", v), err, 1);
                check($sformatf("sweep_code_%0d", v), code, 0);
                check($sformatf("sweep_lat_%0d", v), lat, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
